// File: rtl/tetris_input_ctrl.sv
// Purpose : ADC joystick axes -> hysteretic direction levels + DAS/ARR move pulses; pushbuttons -> debounced levels + press pulses.
// Latency : axis sample on cycle t shows on level/pulse at t+1; raw button change shows at t+DEBOUNCE_CYC+2.
// Backpressure: none; samples are consumed only when adc_valid is high, outputs are single-cycle strobes or levels.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   enable            - gates axis levels/pulses (game running, not paused); buttons are never gated
//   adc_value/valid   - packed per-axis samples (axis i at [i*ADC_W +: ADC_W]) and their strobes
//   btn_raw           - asynchronous pushbutton pins
//   axis_*_level      - axis currently in POS/NEG zone (registered, enable-gated)
//   axis_*_pulse      - one-cycle move pulses (initial, then delayed auto-shift, then auto-repeat)
//   btn_level/press   - debounced pressed state and one-cycle press strobe
module tetris_input_ctrl #(
    parameter int N_AXES         = 2,
    parameter int ADC_W          = 12,
    parameter int CENTER         = 1650,
    parameter int DEADBAND       = 356,
    parameter int HYST           = 64,
    parameter int DAS_CYC        = 8000000,
    parameter int ARR_CYC        = 2500000,
    parameter int N_BTN          = 3,
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_AXES*ADC_W-1:0] adc_value,
    input  logic [N_AXES-1:0]       adc_valid,
    input  logic [N_BTN-1:0]        btn_raw,
    output logic [N_AXES-1:0]       axis_pos_level,
    output logic [N_AXES-1:0]       axis_neg_level,
    output logic [N_AXES-1:0]       axis_pos_pulse,
    output logic [N_AXES-1:0]       axis_neg_pulse,
    output logic [N_BTN-1:0]        btn_level,
    output logic [N_BTN-1:0]        btn_press
);

    typedef enum logic [1:0] {Z_NEUTRAL, Z_POS, Z_NEG} zone_t;
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    // Thresholds carry one extra bit so CENTER+DEADBAND cannot wrap.
    localparam int AW1 = ADC_W + 1;
    localparam logic [AW1-1:0] HI_ENTER = AW1'(CENTER + DEADBAND);
    localparam logic [AW1-1:0] LO_ENTER = AW1'(CENTER - DEADBAND);
    localparam logic [AW1-1:0] HI_EXIT  = AW1'(CENTER + DEADBAND - HYST);
    localparam logic [AW1-1:0] LO_EXIT  = AW1'(CENTER - DEADBAND + HYST);

    localparam int CNT_MAX = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_CYC - 1);
    localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_CYC - 1);

    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic BTN_INV = (BTN_ACTIVE_LOW != 0);

    for (genvar i = 0; i < N_AXES; i++) begin : g_axis
        logic [AW1-1:0]   sample;
        zone_t            zone;
        zone_t            zone_nxt;
        zone_t            dir;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             pos_lvl;
        logic             neg_lvl;
        logic             pos_pls;
        logic             neg_pls;

        assign sample = {1'b0, adc_value[i*ADC_W +: ADC_W]};

        // Entry needs the full deadband, exit only deadband-minus-hysteresis;
        // crossing the opposite entry threshold reverses directly.
        always_comb begin
            zone_nxt = zone;
            if (adc_valid[i]) begin
                case (zone)
                    Z_NEUTRAL: begin
                        if (sample > HI_ENTER)      zone_nxt = Z_POS;
                        else if (sample < LO_ENTER) zone_nxt = Z_NEG;
                    end
                    Z_POS: begin
                        if (sample < LO_ENTER)      zone_nxt = Z_NEG;
                        else if (sample < HI_EXIT)  zone_nxt = Z_NEUTRAL;
                    end
                    Z_NEG: begin
                        if (sample > HI_ENTER)      zone_nxt = Z_POS;
                        else if (sample > LO_EXIT)  zone_nxt = Z_NEUTRAL;
                    end
                    default: zone_nxt = Z_NEUTRAL;
                endcase
            end
        end

        // The repeat FSM looks at zone_nxt so the initial pulse lands in the
        // same cycle the registered zone/level first shows active.
        always_ff @(posedge clk) begin
            if (reset) begin
                zone    <= Z_NEUTRAL;
                dir     <= Z_NEUTRAL;
                state   <= S_IDLE;
                cnt     <= '0;
                pos_lvl <= 1'b0;
                neg_lvl <= 1'b0;
                pos_pls <= 1'b0;
                neg_pls <= 1'b0;
            end else begin
                zone    <= zone_nxt;
                pos_pls <= 1'b0;
                neg_pls <= 1'b0;
                if (!enable) begin
                    state   <= S_IDLE;
                    dir     <= Z_NEUTRAL;
                    cnt     <= '0;
                    pos_lvl <= 1'b0;
                    neg_lvl <= 1'b0;
                end else begin
                    pos_lvl <= (zone_nxt == Z_POS);
                    neg_lvl <= (zone_nxt == Z_NEG);
                    if (zone_nxt == Z_NEUTRAL) begin
                        state <= S_IDLE;
                        dir   <= Z_NEUTRAL;
                        cnt   <= '0;
                    end else if (state == S_IDLE || zone_nxt != dir) begin
                        // Fresh press or direct reversal: pulse the new direction, restart DAS.
                        pos_pls <= (zone_nxt == Z_POS);
                        neg_pls <= (zone_nxt == Z_NEG);
                        dir     <= zone_nxt;
                        cnt     <= DAS_LOAD;
                        state   <= S_DELAY;
                    end else if (cnt == '0) begin
                        pos_pls <= (dir == Z_POS);
                        neg_pls <= (dir == Z_NEG);
                        cnt     <= ARR_LOAD;
                        state   <= S_REPEAT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            end
        end

        assign axis_pos_level[i] = pos_lvl;
        assign axis_neg_level[i] = neg_lvl;
        assign axis_pos_pulse[i] = pos_pls;
        assign axis_neg_pulse[i] = neg_pls;
    end

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        logic             sync1;
        logic             sync2;
        logic             pressed_now;
        logic             state;
        logic             press;
        logic [DEB_W-1:0] cnt;

        assign pressed_now = sync2 ^ BTN_INV;

        always_ff @(posedge clk) begin
            if (reset) begin
                // Synchroniser idles at the released pin level so reset exit is quiet.
                sync1 <= BTN_INV;
                sync2 <= BTN_INV;
                state <= 1'b0;
                press <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= btn_raw[b];
                sync2 <= sync1;
                press <= 1'b0;
                if (pressed_now == state) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    state <= pressed_now;
                    press <= pressed_now;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DEB_W'(1);
                end
            end
        end

        assign btn_level[b] = state;
        assign btn_press[b] = press;
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Purpose : directed self-check of tetris_input_ctrl with short DAS/ARR/debounce timing.
// Latency : expected outputs per cycle are hand-derived tables; cycle 0 is the first cycle with reset low.
// Backpressure: n/a.
module tb_tetris_input_ctrl;

    localparam int N_AXES = 2;
    localparam int ADC_W  = 12;
    localparam int N_BTN  = 3;

    logic                    clk;
    logic                    reset;
    logic                    enable;
    logic [N_AXES*ADC_W-1:0] adc_value;
    logic [N_AXES-1:0]       adc_valid;
    logic [N_BTN-1:0]        btn_raw;
    logic [N_AXES-1:0]       axis_pos_level;
    logic [N_AXES-1:0]       axis_neg_level;
    logic [N_AXES-1:0]       axis_pos_pulse;
    logic [N_AXES-1:0]       axis_neg_pulse;
    logic [N_BTN-1:0]        btn_level;
    logic [N_BTN-1:0]        btn_press;

    int n_checks = 0;
    int n_fail   = 0;

    tetris_input_ctrl #(
        .N_AXES(N_AXES), .ADC_W(ADC_W), .CENTER(1650), .DEADBAND(356), .HYST(64),
        .DAS_CYC(10), .ARR_CYC(4), .N_BTN(N_BTN), .DEBOUNCE_CYC(5), .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .adc_value(adc_value),
        .adc_valid(adc_valid),
        .btn_raw(btn_raw),
        .axis_pos_level(axis_pos_level),
        .axis_neg_level(axis_neg_level),
        .axis_pos_pulse(axis_pos_pulse),
        .axis_neg_pulse(axis_neg_pulse),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order: pos_level, neg_level, pos_pulse, neg_pulse (2b each), btn_level, btn_press (3b each).
    function automatic logic [13:0] outs();
        return {axis_pos_level, axis_neg_level, axis_pos_pulse, axis_neg_pulse, btn_level, btn_press};
    endfunction

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    localparam int LEN [1:7] = '{24, 40, 40, 15, 24, 31, 46};

    task automatic set_inputs(input int t, input int k);
        logic [ADC_W-1:0] a0;
        logic [ADC_W-1:0] a1;
        a0        = 12'd1650;
        a1        = 12'd1650;
        reset     = 1'b0;
        enable    = 1'b1;
        adc_valid = 2'b11;
        btn_raw   = 3'b111;
        case (t)
            1: a0 = 12'd2100;
            2: a0 = (k == 0) ? 12'd2010 : (k <= 30) ? 12'd1960 : 12'd1940;
            3: begin
                a1 = (k <= 19) ? 12'd1200 : (k == 20) ? 12'd2100 : 12'd1650;
                if (k > 20) adc_valid[1] = 1'b0;
            end
            4: btn_raw[0] = !(k <= 2);
            5: btn_raw[0] = !(k <= 11);
            6: begin
                a0    = 12'd2100;
                reset = (k == 13);
            end
            7: begin
                a0     = 12'd2100;
                enable = !(k >= 5 && k <= 29);
            end
            default: ;
        endcase
        adc_value = {a1, a0};
    endtask

    function automatic logic [13:0] exp_out(input int t, input int k);
        logic [1:0] pl, nl, pp, np;
        logic [2:0] bl, bp;
        pl = '0; nl = '0; pp = '0; np = '0; bl = '0; bp = '0;
        case (t)
            1: begin
                pl[0] = (k >= 1);
                pp[0] = (k == 1) || (k >= 11 && (k - 11) % 4 == 0);
            end
            2: begin
                pl[0] = (k >= 1 && k <= 31);
                pp[0] = k inside {1, 11, 15, 19, 23, 27, 31};
            end
            3: begin
                nl[1] = (k >= 1 && k <= 20);
                pl[1] = (k >= 21);
                np[1] = k inside {1, 11, 15, 19};
                pp[1] = k inside {21, 31, 35, 39};
            end
            5: begin
                bl[0] = (k >= 7 && k <= 18);
                bp[0] = (k == 7);
            end
            6: begin
                pl[0] = (k >= 1 && k != 14);
                pp[0] = k inside {1, 11, 15, 25, 29};
            end
            7: begin
                pl[0] = (k >= 1 && k <= 5) || (k >= 31);
                pp[0] = k inside {1, 31, 41, 45};
            end
            default: ;
        endcase
        return {pl, nl, pp, np, bl, bp};
    endfunction

    // Leaves the bench just after the posedge that starts cycle 0, with reset
    // having been high through the previous cycle.
    task automatic do_reset(input int t);
        reset     = 1'b1;
        enable    = 1'b1;
        adc_value = {12'd1650, 12'd1650};
        adc_valid = 2'b11;
        btn_raw   = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq($sformatf("t%0d_reset", t), outs(), 14'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        adc_value = '0;
        adc_valid = '0;
        btn_raw   = 3'b111;
        #1;
        for (int t = 1; t <= 7; t++) begin
            do_reset(t);
            for (int k = 0; k <= LEN[t]; k++) begin
                set_inputs(t, k);
                @(negedge clk);
                check_eq($sformatf("t%0d_c%0d", t, k), outs(), exp_out(t, k));
                @(posedge clk);
                #1;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
